amplifier_mc: RTL and testbench

//  Multi-channel, flow-controlled successor of the single-channel amplifier.
//  - Holds NUM_CH independent scaler registers.
//  - Multiplies tagged base samples by the selected channel's scaler.
//  - Buffers results in an output FIFO with valid/ready backpressure.
//  - Sits between the stimulus/agent side (wr_*) and the result consumer (rd_*).

---
 rtl/amplifier_mc.sv | 164 ++++++++++++++++
 tb/tb_amplifier_mc.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/amplifier_mc.sv
// amplifier_mc: multi-channel scaler/multiplier with a result FIFO.
// Tagged base samples are multiplied by a per-channel scaler, held for one
// pipe stage, then queued with valid/ready backpressure toward the consumer.
// Optional build macro AMP_SAT_EN: saturate results instead of wrapping.
module amplifier_mc #(
  parameter int NUM_CH       = 4,
  parameter int ID_WIDTH     = 8,
  parameter int BASE_WIDTH   = 8,
  parameter int SCALER_WIDTH = 16,
  parameter int RES_WIDTH    = 20,
  parameter int FIFO_DEPTH   = 4,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           wr_en_i,
  input  logic                           set_scaler_i,
  input  logic [CH_W-1:0]                ch_sel_i,
  input  logic [ID_WIDTH+BASE_WIDTH-1:0] wr_data_i,
  output logic                           wr_ready_o,
  output logic                           rd_val_o,
  input  logic                           rd_ready_i,
  output logic [ID_WIDTH+RES_WIDTH-1:0]  rd_data_o,
  output logic [CH_W-1:0]                rd_ch_o,
  output logic [NUM_CH*SCALER_WIDTH-1:0] scaler_o
);

  localparam int PROD_W = BASE_WIDTH + SCALER_WIDTH;
  localparam int DOUT_W = ID_WIDTH + RES_WIDTH;
  localparam int EXT_W  = ((PROD_W > RES_WIDTH) ? PROD_W : RES_WIDTH) + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  // Fit the raw product into the result field: clamp or keep the LSBs.
  function automatic logic [RES_WIDTH-1:0] fit_res(input logic [PROD_W-1:0] prod);
    logic [EXT_W-1:0] ext;
`ifdef AMP_SAT_EN
    logic [EXT_W-1:0] lim;
    lim = EXT_W'({RES_WIDTH{1'b1}});
`endif
    ext = EXT_W'(prod);
`ifdef AMP_SAT_EN
    if (ext > lim) ext = lim;
`endif
    return ext[RES_WIDTH-1:0];
  endfunction

  // FIFO pointer advance with wrap for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [SCALER_WIDTH-1:0] scaler_q [NUM_CH];
  logic [SCALER_WIDTH-1:0] scaler_sel_p0;
  logic [PROD_W-1:0]       prod_p0;
  logic                    accept_p0;
  logic                    vld_p1;
  logic [DOUT_W-1:0]       data_p1;
  logic [CH_W-1:0]         ch_p1;
  logic [DOUT_W-1:0]       mem_data [FIFO_DEPTH];
  logic [CH_W-1:0]         mem_ch   [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        cnt;
  logic                    push;
  logic                    pop;
  logic                    head_ld;
  logic [DOUT_W-1:0]       head_data;
  logic [CH_W-1:0]         head_ch;

  // ---- stage p0: scaler select and multiply on the incoming sample ----
  // Out-of-range channels match no register and select a zero scaler.
  always_comb begin
    scaler_sel_p0 = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_sel_i == CH_W'(i)) scaler_sel_p0 = scaler_q[i];
  end

  assign prod_p0   = PROD_W'(wr_data_i[BASE_WIDTH-1:0]) * PROD_W'(scaler_sel_p0);
  assign accept_p0 = wr_en_i & ~set_scaler_i & wr_ready_o;

  // Scaler register writes; always accepted, unknown channels dropped.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_CH; i++) scaler_q[i] <= '0;
    end else if (wr_en_i && set_scaler_i) begin
      for (int i = 0; i < NUM_CH; i++)
        if (ch_sel_i == CH_W'(i)) scaler_q[i] <= wr_data_i[SCALER_WIDTH-1:0];
    end
  end

  // Flatten the scaler bank onto the status output, channel 0 in the LSBs.
  always_comb begin
    scaler_o = '0;
    for (int i = 0; i < NUM_CH; i++)
      scaler_o[i*SCALER_WIDTH +: SCALER_WIDTH] = scaler_q[i];
  end

  // ---- stage p1: pipe register holding {id, result} and channel ----
  // Pipe valid flag is control state and follows the async reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) vld_p1 <= 1'b0;
    else         vld_p1 <= accept_p0;
  end

  // Pipe payload captured only on accept; no reset needed for data.
  always_ff @(posedge clk_i) begin
    if (accept_p0) begin
      data_p1 <= {wr_data_i[ID_WIDTH+BASE_WIDTH-1:BASE_WIDTH], fit_res(prod_p0)};
      ch_p1   <= ch_sel_i;
    end
  end

  // ---- stage p2: result FIFO with registered head ----
  assign push       = vld_p1;
  assign rd_val_o   = (cnt != '0);
  assign pop        = rd_val_o & rd_ready_i;
  // Counting the pipe entry reserves its slot, so a push never overflows.
  assign wr_ready_o = (({1'b0, cnt} + {{CNT_W{1'b0}}, vld_p1}) < (CNT_W+1)'(FIFO_DEPTH));

  // Next head: the following entry after a pop, or the pushed entry when
  // the FIFO drains to (or starts from) empty; otherwise the head holds.
  always_comb begin
    head_ld   = 1'b0;
    head_data = data_p1;
    head_ch   = ch_p1;
    if (pop && (cnt > CNT_W'(1))) begin
      head_ld   = 1'b1;
      head_data = mem_data[next_ptr(rd_ptr)];
      head_ch   = mem_ch[next_ptr(rd_ptr)];
    end else if (push && (pop || (cnt == '0))) begin
      head_ld   = 1'b1;
    end
  end

  // FIFO storage write; contents are never observed unless counted.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= data_p1;
      mem_ch[wr_ptr]   <= ch_p1;
    end
  end

  // FIFO pointers, occupancy and the registered output head.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      rd_data_o <= '0;
      rd_ch_o   <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (!push && pop) cnt <= cnt - 1'b1;
      if (head_ld) begin
        rd_data_o <= head_data;
        rd_ch_o   <= head_ch;
      end
    end
  end

endmodule

// File: tb/tb_amplifier_mc.sv
// Scoreboard bench for amplifier_mc: expected results are queued when a
// sample is accepted and compared as the consumer takes each result.
module tb_amplifier_mc;

  localparam int NUM_CH = 4, ID_WIDTH = 8, BASE_WIDTH = 8, SCALER_WIDTH = 16;
  localparam int RES_WIDTH = 20, FIFO_DEPTH = 4, CH_W = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_en = 1'b0;
  logic        set_scaler = 1'b0;
  logic [1:0]  ch_sel = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic        rd_val;
  logic        rd_ready = 1'b0;
  logic [27:0] rd_data;
  logic [1:0]  rd_ch;
  logic [63:0] scaler_o;

  typedef struct packed {
    logic [27:0] data;
    logic [1:0]  ch;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned sc_model [NUM_CH];
  int          acc;

  amplifier_mc #(
    .NUM_CH(NUM_CH), .ID_WIDTH(ID_WIDTH), .BASE_WIDTH(BASE_WIDTH),
    .SCALER_WIDTH(SCALER_WIDTH), .RES_WIDTH(RES_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .wr_en_i(wr_en), .set_scaler_i(set_scaler),
    .ch_sel_i(ch_sel), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
    .rd_val_o(rd_val), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
    .rd_ch_o(rd_ch), .scaler_o(scaler_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference result: full-precision product, then clamp or truncate.
  function automatic logic [19:0] model_res(input int unsigned base, input int unsigned scl);
    longint unsigned p;
    p = longint'(base) * longint'(scl);
`ifdef AMP_SAT_EN
    if (p > 64'hFFFFF) return 20'hFFFFF;
`endif
    return p[19:0];
  endfunction

  // Callers start #1 after a rising edge and return at the same phase.
  task automatic set_scl(input int ch, input int unsigned val);
    wr_en = 1'b1; set_scaler = 1'b1; ch_sel = 2'(ch); wr_data = 16'(val);
    @(posedge clk);
    sc_model[ch] = val;
    #1;
    wr_en = 1'b0; set_scaler = 1'b0;
  endtask

  task automatic send_data(input int ch, input int id, input int unsigned base);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    wr_en = 1'b1; set_scaler = 1'b0; ch_sel = 2'(ch); wr_data = {8'(id), 8'(base)};
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (wr_ready) begin
        e.data = {8'(id), model_res(base, sc_model[ch])};
        e.ch   = 2'(ch);
        sb.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && sb.size() != 0; t++) @(negedge clk);
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Consumer-side monitor: pop and compare on each handshake, and check
  // that a stalled head stays put.
  logic        prev_stall = 1'b0;
  logic [27:0] prev_data = '0;
  logic [1:0]  prev_ch = '0;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && rd_val) begin
        chk("hold_data", 64'(rd_data), 64'(prev_data));
        chk("hold_ch", 64'(rd_ch), 64'(prev_ch));
      end
      if (rd_val && rd_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 64'(rd_val), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rd_data", 64'(rd_data), 64'(mon_e.data));
          chk("rd_ch", 64'(rd_ch), 64'(mon_e.ch));
        end
      end
      prev_stall <= rd_val && !rd_ready;
      prev_data  <= rd_data;
      prev_ch    <= rd_ch;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NUM_CH; i++) sc_model[i] = 0;
    #22 rstn = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    chk("rst_rd_val", 64'(rd_val), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_scaler_o", scaler_o, 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_ch", 64'(rd_ch), 64'd0);

    // Basic product and two-edge latency
    rd_ready = 1'b1;
    set_scl(1, 100);
    chk("scaler_o_ch1", 64'(scaler_o[31:16]), 64'd100);
    send_data(1, 5, 25);
    @(negedge clk);
    chk("lat_edge1_val", 64'(rd_val), 64'd0);
    @(negedge clk);
    chk("lat_edge2_val", 64'(rd_val), 64'd1);
    chk("lat_edge2_data", 64'(rd_data), 64'({8'd5, 20'd2500}));
    chk("lat_edge2_ch", 64'(rd_ch), 64'd1);
    @(negedge clk);
    chk("lat_edge3_val", 64'(rd_val), 64'd0);
    chk("empty_hold_data", 64'(rd_data), 64'({8'd5, 20'd2500}));
    @(posedge clk);
    #1;

    // Overflow of the result field
    set_scl(2, 10000);
    chk("scaler_o_ch2", 64'(scaler_o[47:32]), 64'd10000);
    send_data(2, 7, 200);
    @(negedge clk);
    @(negedge clk);
`ifdef AMP_SAT_EN
    chk("ovf_result", 64'(rd_data[19:0]), 64'd1048575);
`else
    chk("ovf_result", 64'(rd_data[19:0]), 64'd951424);
`endif
    @(posedge clk);
    #1;
    drain();

    // Backpressure: consumer stalled, six samples offered back to back
    set_scl(3, 7);
    rd_ready = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      wr_en = 1'b1; set_scaler = 1'b0; ch_sel = 2'd3;
      wr_data = {8'(16 + acc), 8'(acc + 1)};
      @(negedge clk);
      if (wr_ready && acc < 6) begin
        mon_e.data = {8'(16 + acc), model_res(acc + 1, sc_model[3])};
        mon_e.ch   = 2'd3;
        sb.push_back(mon_e);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    chk("bp_accepted", 64'(acc), 64'd4);
    chk("bp_ready_low", 64'(wr_ready), 64'd0);
    chk("bp_val_high", 64'(rd_val), 64'd1);
    rd_ready = 1'b1;
    while (acc < 6) begin
      send_data(3, 16 + acc, acc + 1);
      acc++;
    end
    drain();
    chk("bp_ready_back", 64'(wr_ready), 64'd1);

    // Scaler update right behind a sample: sample keeps the old scaler
    set_scl(0, 3);
    send_data(0, 9, 10);
    set_scl(0, 9);
    send_data(0, 10, 10);
    drain();
    chk("scaler_o_ch0", 64'(scaler_o[15:0]), 64'd9);

    // Reset with three results buffered
    rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_data(1, 40 + k, k + 2);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_val_before", 64'(rd_val), 64'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_val_async", 64'(rd_val), 64'd0);
    chk("mid_rst_ready", 64'(wr_ready), 64'd1);
    sb.delete();
    for (int i = 0; i < NUM_CH; i++) sc_model[i] = 0;
    repeat (2) @(posedge clk);
    #3 rstn = 1'b1;
    rd_ready = 1'b1;
    chk("mid_rst_scaler_o", scaler_o, 64'd0);
    chk("mid_rst_rd_data", 64'(rd_data), 64'd0);
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(rd_val), 64'd0);
    end
    @(posedge clk);
    #1;

    // Normal operation resumes after reset
    set_scl(1, 4);
    send_data(1, 1, 3);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
